// File: rtl/cve2_wb_stage.sv
// Writeback stage: single-entry holding register between ID/EX and the
// register file. ALU results retire the cycle after capture. Loads and stores
// wait for their LSU response, with no limit on how long they wait.
//
// Ports:
//   clk_i, rst_i           clock and synchronous active-high reset
//   en_wb_i ..             instruction offer from ID/EX (type, pc, waddr, wdata, we)
//   lsu_resp_*_i           LSU response (valid, err, load data)
//   ready_wb_o             can accept an offer this cycle
//   rf_*_wb_o              register-file write port
//   instr_done_wb_o        retire pulse
//   pc_wb_o                PC of the held instruction
//   load_err_wb_o          load/store retired with a bus error
//   outstanding_*_wb_o     held load/store is waiting for its response
//   rf_wdata_fwd_wb_o      held EX result, forwarded to ID
module cve2_wb_stage #(
   parameter bit          ResetAll = 1'b1,
   parameter int unsigned RfAddrW  = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,

   input  logic               en_wb_i,
   input  logic [1:0]         instr_type_wb_i,
   input  logic [31:0]        pc_id_i,
   input  logic [RfAddrW-1:0] rf_waddr_id_i,
   input  logic [31:0]        rf_wdata_id_i,
   input  logic               rf_we_id_i,

   input  logic               lsu_resp_valid_i,
   input  logic               lsu_resp_err_i,
   input  logic [31:0]        rf_wdata_lsu_i,

   output logic               ready_wb_o,
   output logic               rf_we_wb_o,
   output logic [RfAddrW-1:0] rf_waddr_wb_o,
   output logic [31:0]        rf_wdata_wb_o,
   output logic               instr_done_wb_o,
   output logic [31:0]        pc_wb_o,
   output logic               load_err_wb_o,
   output logic               outstanding_load_wb_o,
   output logic               outstanding_store_wb_o,
   output logic [31:0]        rf_wdata_fwd_wb_o
);

   localparam logic [1:0] TypeAlu   = 2'b00;
   localparam logic [1:0] TypeLoad  = 2'b01;
   localparam logic [1:0] TypeStore = 2'b10;

   logic               r_wb_valid;
   logic               r_rf_we;
   logic [1:0]         r_type;
   logic [31:0]        r_pc;
   logic [RfAddrW-1:0] r_rf_waddr;
   logic [31:0]        r_rf_wdata;

   logic w_is_load;
   logic w_is_store;
   logic w_is_alu;
   logic w_wb_done;
   logic w_ready;
   logic w_capture;
   logic w_we_allowed;

   // Reserved type 2'b11 behaves as ALU (retires next cycle) but never writes.
   assign w_is_load  = (r_type == TypeLoad);
   assign w_is_store = (r_type == TypeStore);
   assign w_is_alu   = ~w_is_load & ~w_is_store;

   // Gated by reset so a response coinciding with reset cannot write the RF.
   assign w_wb_done = ~rst_i & r_wb_valid & (w_is_alu | lsu_resp_valid_i);
   assign w_ready   = ~r_wb_valid | w_wb_done;
   assign w_capture = ~rst_i & en_wb_i & w_ready;

   // Only ALU and LOAD classes may write; stores and the reserved type drop rf_we.
   assign w_we_allowed = (instr_type_wb_i == TypeAlu) | (instr_type_wb_i == TypeLoad);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wb_valid <= 1'b0;
         r_rf_we    <= 1'b0;
      end else if (w_capture) begin
         r_wb_valid <= 1'b1;
         r_rf_we    <= rf_we_id_i & w_we_allowed;
      end else if (w_wb_done) begin
         r_wb_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         if (ResetAll) begin
            r_type     <= TypeAlu;
            r_pc       <= 32'h0;
            r_rf_waddr <= '0;
            r_rf_wdata <= 32'h0;
         end
      end else if (w_capture) begin
         r_type     <= instr_type_wb_i;
         r_pc       <= pc_id_i;
         r_rf_waddr <= rf_waddr_id_i;
         r_rf_wdata <= rf_wdata_id_i;
      end
   end

   always_comb begin
      ready_wb_o             = w_ready;
      instr_done_wb_o        = w_wb_done;
      rf_we_wb_o             = w_wb_done & r_rf_we & ~(w_is_load & lsu_resp_err_i);
      rf_waddr_wb_o          = r_rf_waddr;
      rf_wdata_wb_o          = w_is_load ? rf_wdata_lsu_i : r_rf_wdata;
      pc_wb_o                = r_pc;
      load_err_wb_o          = w_wb_done & lsu_resp_err_i & (w_is_load | w_is_store);
      outstanding_load_wb_o  = r_wb_valid & w_is_load;
      outstanding_store_wb_o = r_wb_valid & w_is_store;
      rf_wdata_fwd_wb_o      = r_rf_wdata;
   end

endmodule

// File: tb/tb_cve2_wb_stage.sv
module tb_cve2_wb_stage;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        en_wb_i = 1'b0;
   logic [1:0]  instr_type_wb_i = 2'b00;
   logic [31:0] pc_id_i = 32'h0;
   logic [4:0]  rf_waddr_id_i = 5'd0;
   logic [31:0] rf_wdata_id_i = 32'h0;
   logic        rf_we_id_i = 1'b0;
   logic        lsu_resp_valid_i = 1'b0;
   logic        lsu_resp_err_i = 1'b0;
   logic [31:0] rf_wdata_lsu_i = 32'h0;

   logic        ready_wb_o;
   logic        rf_we_wb_o;
   logic [4:0]  rf_waddr_wb_o;
   logic [31:0] rf_wdata_wb_o;
   logic        instr_done_wb_o;
   logic [31:0] pc_wb_o;
   logic        load_err_wb_o;
   logic        outstanding_load_wb_o;
   logic        outstanding_store_wb_o;
   logic [31:0] rf_wdata_fwd_wb_o;

   cve2_wb_stage #(.ResetAll(1'b1), .RfAddrW(5)) u_dut (
      .clk_i                  (clk_i),
      .rst_i                  (rst_i),
      .en_wb_i                (en_wb_i),
      .instr_type_wb_i        (instr_type_wb_i),
      .pc_id_i                (pc_id_i),
      .rf_waddr_id_i          (rf_waddr_id_i),
      .rf_wdata_id_i          (rf_wdata_id_i),
      .rf_we_id_i             (rf_we_id_i),
      .lsu_resp_valid_i       (lsu_resp_valid_i),
      .lsu_resp_err_i         (lsu_resp_err_i),
      .rf_wdata_lsu_i         (rf_wdata_lsu_i),
      .ready_wb_o             (ready_wb_o),
      .rf_we_wb_o             (rf_we_wb_o),
      .rf_waddr_wb_o          (rf_waddr_wb_o),
      .rf_wdata_wb_o          (rf_wdata_wb_o),
      .instr_done_wb_o        (instr_done_wb_o),
      .pc_wb_o                (pc_wb_o),
      .load_err_wb_o          (load_err_wb_o),
      .outstanding_load_wb_o  (outstanding_load_wb_o),
      .outstanding_store_wb_o (outstanding_store_wb_o),
      .rf_wdata_fwd_wb_o      (rf_wdata_fwd_wb_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] pc;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
      end
   endtask

   // Monitor: every retire pulse pops the oldest expected retirement.
   exp_t m_e;
   always @(negedge clk_i) begin
      if (instr_done_wb_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(instr_done_wb_o), 32'h0);
         end else begin
            m_e = exp_q.pop_front();
            chk("ret_pc", pc_wb_o, m_e.pc);
            chk("ret_we", 32'(rf_we_wb_o), 32'(m_e.we));
            chk("ret_err", 32'(load_err_wb_o), 32'(m_e.err));
            if (m_e.we) begin
               chk("ret_addr", 32'(rf_waddr_wb_o), 32'(m_e.addr));
               chk("ret_data", rf_wdata_wb_o, m_e.data);
            end
         end
      end else if (rf_we_wb_o || load_err_wb_o) begin
         chk("we_or_err_without_done", {30'h0, rf_we_wb_o, load_err_wb_o}, 32'h0);
      end
   end

   task automatic edge_drive();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      en_wb_i = 1'b0;
      lsu_resp_valid_i = 1'b0;
      lsu_resp_err_i = 1'b0;
   endtask

   task automatic offer(input logic [1:0] t, input logic [31:0] pc, input logic [4:0] a,
                        input logic [31:0] d, input logic we);
      en_wb_i = 1'b1;
      instr_type_wb_i = t;
      pc_id_i = pc;
      rf_waddr_id_i = a;
      rf_wdata_id_i = d;
      rf_we_id_i = we;
   endtask

   task automatic resp(input logic err, input logic [31:0] d);
      lsu_resp_valid_i = 1'b1;
      lsu_resp_err_i = err;
      rf_wdata_lsu_i = d;
   endtask

   task automatic push(input logic [31:0] pc, input logic we, input logic [4:0] a,
                       input logic [31:0] d, input logic err);
      exp_t e;
      e.pc = pc; e.we = we; e.addr = a; e.data = d; e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(ready_wb_o), 32'h1);
      chk({tag, "_we"}, 32'(rf_we_wb_o), 32'h0);
      chk({tag, "_done"}, 32'(instr_done_wb_o), 32'h0);
      chk({tag, "_err"}, 32'(load_err_wb_o), 32'h0);
      chk({tag, "_outld"}, 32'(outstanding_load_wb_o), 32'h0);
      chk({tag, "_outst"}, 32'(outstanding_store_wb_o), 32'h0);
      chk({tag, "_pc"}, pc_wb_o, 32'h0);
      chk({tag, "_waddr"}, 32'(rf_waddr_wb_o), 32'h0);
      chk({tag, "_fwd"}, rf_wdata_fwd_wb_o, 32'h0);
   endtask

   initial begin
      // Reset, with an offer present that must be ignored.
      rst_i = 1'b1;
      offer(2'b00, 32'hFFFF_0000, 5'd3, 32'hBAD, 1'b1);
      edge_drive();
      edge_drive();
      rst_i = 1'b0;
      idle();
      @(negedge clk_i);
      chk_reset_outputs("reset");

      // Back-to-back ALU: zero bubbles.
      edge_drive(); offer(2'b00, 32'h10, 5'd5, 32'h1234, 1'b1); push(32'h10, 1'b1, 5'd5, 32'h1234, 1'b0);
      @(negedge clk_i); chk("b2b_ready0", 32'(ready_wb_o), 32'h1);
      edge_drive(); offer(2'b00, 32'h14, 5'd6, 32'hABCD, 1'b1); push(32'h14, 1'b1, 5'd6, 32'hABCD, 1'b0);
      @(negedge clk_i); chk("b2b_ready1", 32'(ready_wb_o), 32'h1);
      chk("b2b_done1", 32'(instr_done_wb_o), 32'h1);
      chk("b2b_fwd1", rf_wdata_fwd_wb_o, 32'h1234);
      edge_drive(); idle();
      @(negedge clk_i); chk("b2b_ready2", 32'(ready_wb_o), 32'h1);
      chk("b2b_done2", 32'(instr_done_wb_o), 32'h1);
      edge_drive();
      @(negedge clk_i); chk("b2b_done3", 32'(instr_done_wb_o), 32'h0);

      // Load with 3-cycle latency.
      edge_drive(); offer(2'b01, 32'h100, 5'd7, 32'hCAFE, 1'b1);
      push(32'h100, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk_i); chk("ld_ready0", 32'(ready_wb_o), 32'h1);
      for (int i = 1; i <= 2; i++) begin
         edge_drive(); idle();
         @(negedge clk_i);
         chk("ld_ready_wait", 32'(ready_wb_o), 32'h0);
         chk("ld_outstanding", 32'(outstanding_load_wb_o), 32'h1);
         chk("ld_fwd", rf_wdata_fwd_wb_o, 32'hCAFE);
      end
      edge_drive(); resp(1'b0, 32'hDEAD_BEEF);
      @(negedge clk_i); chk("ld_outstanding3", 32'(outstanding_load_wb_o), 32'h1);
      chk("ld_ready3", 32'(ready_wb_o), 32'h1);
      edge_drive(); idle();
      @(negedge clk_i); chk("ld_outstanding4", 32'(outstanding_load_wb_o), 32'h0);

      // Load with bus error: retires without a write.
      edge_drive(); offer(2'b01, 32'h200, 5'd8, 32'h0, 1'b1); push(32'h200, 1'b0, 5'd8, 32'h0, 1'b1);
      edge_drive(); idle(); resp(1'b1, 32'h5555);
      @(negedge clk_i); chk("lderr_err", 32'(load_err_wb_o), 32'h1);
      edge_drive(); idle();
      @(negedge clk_i); chk("lderr_err_after", 32'(load_err_wb_o), 32'h0);

      // Store: never writes even with rf_we_id_i set.
      edge_drive(); offer(2'b10, 32'h300, 5'd9, 32'h77, 1'b1); push(32'h300, 1'b0, 5'd9, 32'h0, 1'b0);
      edge_drive(); idle();
      @(negedge clk_i); chk("st_outstanding", 32'(outstanding_store_wb_o), 32'h1);
      chk("st_outld", 32'(outstanding_load_wb_o), 32'h0);
      edge_drive(); resp(1'b0, 32'h1357);
      @(negedge clk_i); chk("st_outstanding_resp", 32'(outstanding_store_wb_o), 32'h1);
      edge_drive(); idle();
      @(negedge clk_i); chk("st_outstanding_after", 32'(outstanding_store_wb_o), 32'h0);

      // Response and next ALU offer in the same cycle.
      edge_drive(); offer(2'b01, 32'h400, 5'd10, 32'h0, 1'b1); push(32'h400, 1'b1, 5'd10, 32'h77, 1'b0);
      edge_drive(); idle();
      @(negedge clk_i); chk("sim_ready_wait", 32'(ready_wb_o), 32'h0);
      edge_drive(); resp(1'b0, 32'h77);
      offer(2'b00, 32'h404, 5'd9, 32'h42, 1'b1); push(32'h404, 1'b1, 5'd9, 32'h42, 1'b0);
      @(negedge clk_i); chk("sim_ready", 32'(ready_wb_o), 32'h1);
      edge_drive(); idle();
      @(negedge clk_i); chk("sim_alu_done", 32'(instr_done_wb_o), 32'h1);
      edge_drive();

      // Spurious responses: empty, then holding an ALU entry.
      resp(1'b1, 32'h9999);
      @(negedge clk_i); chk("spur_empty_done", 32'(instr_done_wb_o), 32'h0);
      chk("spur_empty_err", 32'(load_err_wb_o), 32'h0);
      edge_drive(); offer(2'b00, 32'h500, 5'd11, 32'h99, 1'b1); push(32'h500, 1'b1, 5'd11, 32'h99, 1'b0);
      resp(1'b1, 32'h9999);
      edge_drive(); en_wb_i = 1'b0;
      @(negedge clk_i); chk("spur_alu_data", rf_wdata_wb_o, 32'h99);
      edge_drive();
      @(negedge clk_i); chk("spur_after_done", 32'(instr_done_wb_o), 32'h0);
      edge_drive(); idle();

      // Reserved type behaves as ALU without a write; x0 still presented.
      offer(2'b11, 32'h580, 5'd12, 32'h5A, 1'b1); push(32'h580, 1'b0, 5'd12, 32'h0, 1'b0);
      edge_drive(); offer(2'b00, 32'h584, 5'd0, 32'hF00D, 1'b1); push(32'h584, 1'b1, 5'd0, 32'hF00D, 1'b0);
      edge_drive(); idle();
      edge_drive();

      // Reset while a load is pending and its response arrives.
      offer(2'b01, 32'h600, 5'd13, 32'h0, 1'b1);
      edge_drive(); idle();
      edge_drive(); rst_i = 1'b1; resp(1'b0, 32'h1111);
      offer(2'b00, 32'h700, 5'd14, 32'h88, 1'b1);
      @(negedge clk_i); chk("rst_mid_we", 32'(rf_we_wb_o), 32'h0);
      chk("rst_mid_done", 32'(instr_done_wb_o), 32'h0);
      edge_drive(); rst_i = 1'b0; idle();
      @(negedge clk_i); chk_reset_outputs("rst_mid");
      edge_drive(); offer(2'b00, 32'h604, 5'd14, 32'h321, 1'b1); push(32'h604, 1'b1, 5'd14, 32'h321, 1'b0);
      edge_drive(); idle();
      @(negedge clk_i); chk("post_rst_done", 32'(instr_done_wb_o), 32'h1);
      edge_drive();
      edge_drive();
      @(negedge clk_i);
      chk("pending_expectations", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
